// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the 8N1 UART transmit/receive pair.
package uart_pkg;

  localparam int unsigned DATA_BITS         = 8;
  localparam int unsigned STOP_BITS         = 1;
  localparam int unsigned CLKS_PER_BIT_9600 = 10417;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte queue feeding the UART transmitter; the head entry is always visible on rdata.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = DATA_BITS
) (
  input  logic             clk_100MHZ,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  // A push while full is dropped even if a pop frees a slot this same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_ff @(posedge clk_100MHZ) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_ok && !pop_ok) begin
        count_q <= count_q + CntW'(1);
      end else if (!push_ok && pop_ok) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_100MHZ) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: queued bytes are serialised LSB first on a registered, idle-high line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_9600,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 clk_100MHZ,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 fifo_full,
  output logic                 overflow,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_out_q, tx_out_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 overflow_q;

  logic                 fifo_pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 baud_tick;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (DATA_BITS)
  ) u_fifo (
    .clk_100MHZ (clk_100MHZ),
    .reset      (reset),
    .push       (data_valid),
    .wdata      (data_in),
    .pop        (fifo_pop),
    .rdata      (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign baud_tick = (baud_q == BaudLast);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    tx_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_tick) begin
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BitW'(1);
          if (bit_q == BitLast) state_d = StStop;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_tick) begin
          tx_done_d = 1'b1;
          baud_d    = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            bit_d    = '0;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line, busy and done are all registered off the current state so they stay cycle-aligned.
  always_comb begin
    tx_out_d = 1'b1;
    unique case (state_q)
      StStart: tx_out_d = 1'b0;
      StData:  tx_out_d = shift_q[0];
      default: tx_out_d = 1'b1;
    endcase
    tx_busy_d = (state_q != StIdle) || !fifo_empty;
  end

  always_ff @(posedge clk_100MHZ) begin
    if (reset) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_out_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_out_q   <= tx_out_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
      overflow_q <= overflow_q | (data_valid & fifo_full);
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with CLKS_PER_BIT=16, FIFO_DEPTH=4.
module tb_uart_tx;

  localparam int unsigned Clks  = 16;
  localparam int unsigned Depth = 4;

  logic       clk_100MHZ = 1'b0;
  logic       reset      = 1'b1;
  logic [7:0] data_in    = 8'h00;
  logic       data_valid = 1'b0;
  logic       fifo_full, overflow, tx_out, tx_busy, tx_done;

  int checks = 0;
  int errors = 0;

  logic       inj_en   = 1'b0;
  logic [7:0] inj_data = 8'h00;
  int         inj_idx  = 0;

  uart_tx #(
    .CLKS_PER_BIT (Clks),
    .FIFO_DEPTH   (Depth)
  ) dut (
    .clk_100MHZ (clk_100MHZ),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .tx_out     (tx_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk_100MHZ = ~clk_100MHZ;

  initial begin
    #5000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_100MHZ);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (tx_out !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    check({tag, " start"}, {31'd0, tx_out}, 32'd0);
  endtask

  // Entered on the sample point of frame cycle 'skip' (cycle 0 is the first start-bit cycle);
  // leaves on the sample point of frame cycle 160.
  task automatic expect_frame(input string tag, input logic [7:0] b, input int skip);
    logic [159:0] obs, exp;
    logic [9:0]   bits;
    int           done_cnt, done_pos, busy_lo;
    bits     = {1'b1, b, 1'b0};
    done_cnt = 0;
    done_pos = -1;
    busy_lo  = 0;
    for (int c = 0; c < 160; c++) begin
      exp[c] = bits[c/16];
      if (c < skip) begin
        obs[c] = exp[c];
      end else begin
        obs[c] = tx_out;
        if (tx_done === 1'b1) begin
          done_cnt++;
          done_pos = c;
        end
        if (tx_busy !== 1'b1) busy_lo++;
        if (inj_en && c == inj_idx) begin
          data_in    = inj_data;
          data_valid = 1'b1;
        end else if (inj_en && c == inj_idx + 1) begin
          data_valid = 1'b0;
        end
        tick();
      end
    end
    for (int k = 0; k < 10; k++) begin
      check($sformatf("%s bit%0d", tag, k), {16'd0, obs[k*16 +: 16]}, {16'd0, exp[k*16 +: 16]});
    end
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " done pos"}, done_pos, 159);
    check({tag, " busy low cycles"}, busy_lo, 0);
    inj_en     = 1'b0;
    data_valid = 1'b0;
  endtask

  initial begin
    int bad_line, bad_busy, bad_done;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset tx_out", {31'd0, tx_out}, 32'd1);
    check("reset tx_busy", {31'd0, tx_busy}, 32'd0);
    check("reset tx_done", {31'd0, tx_done}, 32'd0);
    check("reset fifo_full", {31'd0, fifo_full}, 32'd0);
    check("reset overflow", {31'd0, overflow}, 32'd0);

    // Idle line for 1000 cycles
    bad_line = 0; bad_busy = 0; bad_done = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (tx_out !== 1'b1) bad_line++;
      if (tx_busy !== 1'b0) bad_busy++;
      if (tx_done !== 1'b0) bad_done++;
    end
    check("idle line", bad_line, 0);
    check("idle busy", bad_busy, 0);
    check("idle done", bad_done, 0);

    // Single byte 0xA5 with exact latency
    data_in    = 8'hA5;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("lat N tx_out", {31'd0, tx_out}, 32'd1);
    tick();
    check("lat N+1 tx_out", {31'd0, tx_out}, 32'd1);
    check("lat N+1 tx_busy", {31'd0, tx_busy}, 32'd1);
    tick();
    check("lat N+2 tx_out", {31'd0, tx_out}, 32'd0);
    expect_frame("a5", 8'hA5, 0);
    check("a5 busy after", {31'd0, tx_busy}, 32'd0);
    check("a5 line after", {31'd0, tx_out}, 32'd1);

    // Back-to-back 0x00 then 0xFF, contiguous frames
    data_in    = 8'h00;
    data_valid = 1'b1;
    tick();
    data_in = 8'hFF;
    tick();
    data_valid = 1'b0;
    wait_start("b2b");
    expect_frame("b2b 00", 8'h00, 0);
    expect_frame("b2b ff", 8'hFF, 0);
    check("b2b busy after", {31'd0, tx_busy}, 32'd0);

    // Push coinciding with the STOP-to-START pop while one byte is queued
    data_in    = 8'h5A;
    data_valid = 1'b1;
    tick();
    data_in = 8'hC3;
    tick();
    data_valid = 1'b0;
    wait_start("simul");
    inj_en   = 1'b1;
    inj_data = 8'h96;
    inj_idx  = 158;
    expect_frame("simul 5a", 8'h5A, 0);
    check("simul full", {31'd0, fifo_full}, 32'd0);
    expect_frame("simul c3", 8'hC3, 0);
    expect_frame("simul 96", 8'h96, 0);
    check("simul busy after", {31'd0, tx_busy}, 32'd0);

    // Full/overflow: six consecutive writes, sixth is rejected
    for (int i = 1; i <= 6; i++) begin
      data_in    = 8'(i);
      data_valid = 1'b1;
      tick();
      if (i == 4) check("ovf full after 4", {31'd0, fifo_full}, 32'd0);
      if (i == 5) begin
        check("ovf full after 5", {31'd0, fifo_full}, 32'd1);
        check("ovf overflow after 5", {31'd0, overflow}, 32'd0);
      end
      if (i == 6) begin
        check("ovf full after 6", {31'd0, fifo_full}, 32'd1);
        check("ovf overflow after 6", {31'd0, overflow}, 32'd1);
      end
    end
    data_valid = 1'b0;
    expect_frame("ovf 01", 8'h01, 3);
    expect_frame("ovf 02", 8'h02, 0);
    expect_frame("ovf 03", 8'h03, 0);
    expect_frame("ovf 04", 8'h04, 0);
    expect_frame("ovf 05", 8'h05, 0);
    bad_line = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx_out !== 1'b1) bad_line++;
      tick();
    end
    check("ovf no sixth frame", bad_line, 0);
    check("ovf sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-frame during data bit 3 with two bytes queued
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst clears overflow", {31'd0, overflow}, 32'd0);
    data_valid = 1'b1;
    data_in    = 8'h11;
    tick();
    data_in = 8'h22;
    tick();
    data_in = 8'h33;
    tick();
    data_valid = 1'b0;
    check("rst frame start", {31'd0, tx_out}, 32'd0);
    repeat (70) tick();
    check("rst in data bit3", {31'd0, tx_out}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst tx_out", {31'd0, tx_out}, 32'd1);
    check("rst tx_busy", {31'd0, tx_busy}, 32'd0);
    check("rst tx_done", {31'd0, tx_done}, 32'd0);
    check("rst fifo_full", {31'd0, fifo_full}, 32'd0);
    bad_line = 0; bad_busy = 0; bad_done = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (tx_out !== 1'b1) bad_line++;
      if (tx_busy !== 1'b0) bad_busy++;
      if (tx_done !== 1'b0) bad_done++;
    end
    check("rst quiet line", bad_line, 0);
    check("rst quiet busy", bad_busy, 0);
    check("rst quiet done", bad_done, 0);
    data_in    = 8'h3C;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    wait_start("rst fresh");
    expect_frame("rst 3c", 8'h3C, 0);
    check("rst 3c busy after", {31'd0, tx_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
